// File: rtl/qs_drain_if.sv
// Stream bus around qs_drain: sorter-side push words in, valid/ready words out, plus status.
// master = sorter/consumer side, slave = qs_drain.
interface qs_drain_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
);
    logic             in_vld;
    logic             in_sop;
    logic             in_eop;
    logic             in_err;
    logic [W-1:0]     in_dat;
    logic             out_vld_r;
    logic             out_sop_r;
    logic             out_eop_r;
    logic             out_err_r;
    logic [W-1:0]     out_dat_r;
    logic             out_rdy;
    logic             ovf_r;
    logic [CNT_W-1:0] pkt_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;

    modport master (
        output in_vld, in_sop, in_eop, in_err, in_dat, out_rdy,
        input  out_vld_r, out_sop_r, out_eop_r, out_err_r, out_dat_r,
        input  ovf_r, pkt_cnt_r, drop_cnt_r
    );

    modport slave (
        input  in_vld, in_sop, in_eop, in_err, in_dat, out_rdy,
        output out_vld_r, out_sop_r, out_eop_r, out_err_r, out_dat_r,
        output ovf_r, pkt_cnt_r, drop_cnt_r
    );
endinterface

// File: rtl/qs_drain.sv
// qs_drain: absorbs the sorter's un-throttled word stream into a framed FIFO with a registered head.
// Define QS_DRAIN_ORDER_CHK_EN to flag words that break ascending order within a packet.
module qs_drain #(
    parameter int unsigned W     = 32,
    parameter int unsigned N     = 16,
    parameter int unsigned CNT_W = 16
) (
    input logic       clk,
    input logic       rst,
    qs_drain_if.slave bus
);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned EW = W + 3;

    typedef enum logic [1:0] {StIdle, StPkt, StDrop} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [EW-1:0]    r_mem [N];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_wr_ptr_nxt;
    logic [AW:0]      w_rd_ptr_nxt;
    logic             r_out_vld;
    logic [EW-1:0]    r_out_ent;
    logic [EW-1:0]    w_head_nxt;
    logic [EW-1:0]    w_entry;
    logic             r_ovf;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_full;
    logic             w_pop;
    logic             w_cand;
    logic             w_ferr;
    logic             w_oerr;
    logic             w_ovf_drop;
    logic             w_push;
    logic             w_drop;

    assign w_full = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop  = r_out_vld & bus.out_rdy;

`ifdef QS_DRAIN_ORDER_CHK_EN
    logic [W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
        end else if (w_push) begin
            r_prev <= bus.in_dat;
        end
    end

    assign w_oerr = ~bus.in_sop & (bus.in_dat < r_prev);
`else
    assign w_oerr = 1'b0;
`endif

    assign w_entry = {bus.in_sop, bus.in_eop, bus.in_err | w_ferr | w_oerr, bus.in_dat};

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: outputs (store/drop decision for the current word)
    always_comb begin
        w_cand = 1'b0;
        w_ferr = 1'b0;
        if (bus.in_vld) begin
            case (r_state)
                StIdle:  w_cand = bus.in_sop;
                StPkt: begin
                    w_cand = 1'b1;
                    w_ferr = bus.in_sop;
                end
                StDrop:  w_cand = bus.in_sop;
                default: w_cand = 1'b0;
            endcase
        end
        w_ovf_drop = w_cand & w_full & ~w_pop;
        w_push     = w_cand & ~w_ovf_drop;
        w_drop     = bus.in_vld & ~w_push;
    end

    // FSM: next state; a dropped eop always closes the packet
    always_comb begin
        w_state_nxt = r_state;
        if (bus.in_vld) begin
            if (w_ovf_drop) begin
                w_state_nxt = bus.in_eop ? StIdle : StDrop;
            end else if (w_push) begin
                w_state_nxt = bus.in_eop ? StIdle : StPkt;
            end else if (r_state == StDrop && bus.in_eop) begin
                w_state_nxt = StIdle;
            end
        end
    end

    assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

    // Next head comes straight from the input when it lands in an otherwise empty FIFO
    assign w_head_nxt = (w_rd_ptr_nxt == r_wr_ptr) ? w_entry : r_mem[w_rd_ptr_nxt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_out_vld  <= 1'b0;
            r_out_ent  <= '0;
            r_ovf      <= 1'b0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_out_vld <= (w_rd_ptr_nxt != w_wr_ptr_nxt);
            r_out_ent <= w_head_nxt;
            r_ovf     <= r_ovf | w_ovf_drop;
            if (w_pop && r_out_ent[W+1]) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign bus.out_vld_r  = r_out_vld;
    assign bus.out_sop_r  = r_out_ent[W+2];
    assign bus.out_eop_r  = r_out_ent[W+1];
    assign bus.out_err_r  = r_out_ent[W];
    assign bus.out_dat_r  = r_out_ent[W-1:0];
    assign bus.ovf_r      = r_ovf;
    assign bus.pkt_cnt_r  = r_pkt_cnt;
    assign bus.drop_cnt_r = r_drop_cnt;
endmodule

// File: tb/tb_qs_drain.sv
// Bench for qs_drain: directed scenarios plus random traffic against a queue-based reference.
// Follows QS_DRAIN_ORDER_CHK_EN the same way the design does.
module tb_qs_drain;
    localparam int unsigned W     = 32;
    localparam int unsigned N     = 16;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    qs_drain_if #(.W(W), .CNT_W(CNT_W)) bus ();

    qs_drain #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a queue of {sop,eop,err,dat} plus whether a packet is open
    logic [W+2:0]     m_q[$];
    bit               m_in_pkt;
    bit               m_ovf;
    logic [W-1:0]     m_prev;
    logic [CNT_W-1:0] m_pkt_cnt;
    logic [CNT_W-1:0] m_drop_cnt;

    task automatic model_clear();
        m_q.delete();
        m_in_pkt   = 1'b0;
        m_ovf      = 1'b0;
        m_prev     = '0;
        m_pkt_cnt  = '0;
        m_drop_cnt = '0;
    endtask

    task automatic model_drop();
        if (m_drop_cnt != {CNT_W{1'b1}}) m_drop_cnt = m_drop_cnt + 1'b1;
    endtask

    task automatic model_step(input bit vld, input bit sop, input bit eop, input bit err,
                              input logic [W-1:0] dat, input bit rdy);
        bit           pop;
        bit           store;
        bit           ferr;
        bit           oerr;
        logic [W+2:0] ent;
        pop   = (m_q.size() > 0) && rdy;
        store = 1'b0;
        ent   = '0;
        if (pop && m_q[0][W+1]) m_pkt_cnt = m_pkt_cnt + 1'b1;
        if (vld) begin
            if (!m_in_pkt && !sop) begin
                model_drop();
            end else begin
                ferr = m_in_pkt && sop;
                oerr = 1'b0;
`ifdef QS_DRAIN_ORDER_CHK_EN
                oerr = !sop && (dat < m_prev);
`endif
                if (m_q.size() == N && !pop) begin
                    model_drop();
                    m_ovf    = 1'b1;
                    m_in_pkt = 1'b0;
                end else begin
                    store    = 1'b1;
                    ent      = {sop, eop, err | ferr | oerr, dat};
                    m_in_pkt = !eop;
                    m_prev   = dat;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (store) m_q.push_back(ent);
    endtask

    task automatic compare_all();
        check("out_vld", 64'(bus.out_vld_r), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("out_word", 64'({bus.out_sop_r, bus.out_eop_r, bus.out_err_r, bus.out_dat_r}),
                  64'(m_q[0]));
        end
        check("ovf", 64'(bus.ovf_r), 64'(m_ovf));
        check("pkt_cnt", 64'(bus.pkt_cnt_r), 64'(m_pkt_cnt));
        check("drop_cnt", 64'(bus.drop_cnt_r), 64'(m_drop_cnt));
    endtask

    task automatic cycle(input bit vld, input bit sop, input bit eop, input bit err,
                         input logic [W-1:0] dat, input bit rdy);
        bus.in_vld  = vld;
        bus.in_sop  = sop;
        bus.in_eop  = eop;
        bus.in_err  = err;
        bus.in_dat  = dat;
        bus.out_rdy = rdy;
        model_step(vld, sop, eop, err, dat, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Reset leaves the inputs as they are, so a word in flight is discarded
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check("rst_vld", 64'(bus.out_vld_r), 64'd0);
        check("rst_word", 64'({bus.out_sop_r, bus.out_eop_r, bus.out_err_r, bus.out_dat_r}), 64'd0);
        check("rst_ovf", 64'(bus.ovf_r), 64'd0);
        check("rst_pkt_cnt", 64'(bus.pkt_cnt_r), 64'd0);
        check("rst_drop_cnt", 64'(bus.drop_cnt_r), 64'd0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, rdy);
    endtask

    initial begin
        logic [W-1:0] t1_vals [4];
        logic [W-1:0] t5_vals [4];
        bit           exp_err;
        t1_vals = '{32'd1, 32'd3, 32'd3, 32'd9};
        t5_vals = '{32'd5, 32'd8, 32'd6, 32'd9};
        bus.in_vld  = 1'b0;
        bus.in_sop  = 1'b0;
        bus.in_eop  = 1'b0;
        bus.in_err  = 1'b0;
        bus.in_dat  = '0;
        bus.out_rdy = 1'b0;
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // T1: each word visible the cycle after it is pushed
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i == 0, i == 3, 1'b0, t1_vals[i], 1'b1);
            check("t1_dat", 64'(bus.out_dat_r), 64'(t1_vals[i]));
            check("t1_flags", 64'({bus.out_vld_r, bus.out_sop_r, bus.out_eop_r, bus.out_err_r}),
                  64'({1'b1, i == 0, i == 3, 1'b0}));
        end
        idle(2, 1'b1);
        check("t1_pkt_cnt", 64'(bus.pkt_cnt_r), 64'd1);

        // T2: 20-word packet into a stalled FIFO
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, i == 0, i == 19, 1'b0, 32'(i), 1'b0);
        check("t2_ovf", 64'(bus.ovf_r), 64'd1);
        check("t2_drop_cnt", 64'(bus.drop_cnt_r), 64'd4);
        idle(18, 1'b1);
        check("t2_pkt_cnt", 64'(bus.pkt_cnt_r), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd77, 1'b1);
        check("t2_idle_drop", 64'(bus.drop_cnt_r), 64'd5);

        // T3: stray non-sop word in IDLE
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 1'b1);
        idle(1, 1'b1);
        check("t3_drop_cnt", 64'(bus.drop_cnt_r), 64'd1);
        check("t3_vld", 64'(bus.out_vld_r), 64'd0);

        // T4: unterminated packet followed by a one-word packet
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 1'b1);
        check("t4_head", 64'({bus.out_sop_r, bus.out_eop_r, bus.out_err_r, bus.out_dat_r}),
              64'({1'b1, 1'b1, 1'b1, 32'd4}));
        idle(2, 1'b1);
        check("t4_pkt_cnt", 64'(bus.pkt_cnt_r), 64'd1);

        // T5: out-of-order word inside a packet
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i == 0, i == 3, 1'b0, t5_vals[i], 1'b1);
            exp_err = 1'b0;
`ifdef QS_DRAIN_ORDER_CHK_EN
            exp_err = (i == 2);
`endif
            check("t5_err", 64'({bus.out_dat_r, bus.out_err_r}), 64'({t5_vals[i], exp_err}));
        end
        idle(2, 1'b1);

        // T6: full FIFO, simultaneous push and pop, then reset mid-packet
        do_reset();
        for (int i = 0; i < N; i++) cycle(1'b1, i == 0, 1'b0, 1'b0, 32'(100 + i), 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd200, 1'b1);
        check("t6_no_drop", 64'(bus.drop_cnt_r), 64'd0);
        check("t6_no_ovf", 64'(bus.ovf_r), 64'd0);
        bus.in_vld = 1'b1;
        bus.in_sop = 1'b0;
        bus.in_dat = 32'd201;
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd202, 1'b1);
        check("t6_needs_sop", 64'(bus.drop_cnt_r), 64'd1);

        // Random traffic with varying back-pressure and occasional resets
        do_reset();
        for (int blk = 0; blk < 20; blk++) begin
            int unsigned rdy_pct;
            rdy_pct = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 599) == 0) begin
                    do_reset();
                end else begin
                    cycle($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 25,
                          $urandom_range(0, 99) < 25, $urandom_range(0, 15) == 0,
                          32'($urandom_range(0, 15)), $urandom_range(0, 99) < rdy_pct);
                end
            end
        end
        idle(N + 2, 1'b1);
        check("final_empty", 64'(bus.out_vld_r), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
